// File: rtl/xor_multiport_ram.sv
// XOR-coded multiport RAM: N_WR write and N_RD read ports built from 1W1R banks,
// with same-address forwarding, write-conflict arbitration and a clear sweep after reset.
module xor_multiport_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int N_WR       = 4,
    parameter int N_RD       = 4
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [N_WR-1:0]            i_we,
    input  logic [N_WR*ADDR_WIDTH-1:0] i_wa,
    input  logic [N_WR*DATA_WIDTH-1:0] i_wd,
    input  logic [N_RD-1:0]            i_re,
    input  logic [N_RD*ADDR_WIDTH-1:0] i_ra,
    output logic [N_RD*DATA_WIDTH-1:0] o_rd,
    output logic [N_RD-1:0]            o_rvalid,
    output logic                       o_ready
);
    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int N_BANK = N_WR - 1 + N_RD;
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              state;
    logic [ADDR_WIDTH:0] clr_cnt;
    logic                clearing;

    logic [N_WR-1:0]       we_s0;
    logic [N_WR-1:0]       s1_we;
    logic [ADDR_WIDTH-1:0] s1_wa   [N_WR];
    logic [DATA_WIDTH-1:0] s1_wd   [N_WR];
    logic [DATA_WIDTH-1:0] din     [N_WR];
    logic [N_WR-1:0]       fwd_we;
    logic [ADDR_WIDTH-1:0] fwd_wa  [N_WR];
    logic [DATA_WIDTH-1:0] fwd_din [N_WR];

    logic [N_RD-1:0]       rd_re_q;
    logic [ADDR_WIDTH-1:0] rd_ra_q [N_RD];
    logic [DATA_WIDTH-1:0] rd_next [N_RD];

    // Registered output of bank b belonging to write port w.
    logic [DATA_WIDTH-1:0] bank_q [N_WR][N_BANK];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            o_ready <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + CNT_ONE;
                    if (clr_cnt == CNT_LAST) begin
                        state   <= ST_READY;
                        o_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign clearing = (state == ST_CLEAR);

    // Same-cycle writes to one address: the lowest-index port keeps its enable.
    // NOTE: each output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        for (int w = 0; w < N_WR; w++) begin
            we_s0[w] = i_we[w] & o_ready;
            for (int v = 0; v < w; v++) begin
                if (i_we[v] && (i_wa[v*ADDR_WIDTH +: ADDR_WIDTH] == i_wa[w*ADDR_WIDTH +: ADDR_WIDTH]))
                    we_s0[w] = 1'b0;
            end
        end
    end

    // Encoded write value: wd XOR the other ports' contributions at the same address.
    always_comb begin
        for (int w = 0; w < N_WR; w++) begin
            din[w] = s1_wd[w];
            for (int v = 0; v < N_WR; v++) begin
                if (v != w) begin
                    if (fwd_we[v] && (fwd_wa[v] == s1_wa[w]))
                        din[w] = din[w] ^ fwd_din[v];
                    else
                        din[w] = din[w] ^ bank_q[v][(w < v) ? w : w - 1];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < N_RD; r++) begin
            rd_next[r] = '0;
            for (int w = 0; w < N_WR; w++) begin
                if (fwd_we[w] && (fwd_wa[w] == rd_ra_q[r]))
                    rd_next[r] = rd_next[r] ^ fwd_din[w];
                else
                    rd_next[r] = rd_next[r] ^ bank_q[w][N_WR - 1 + r];
            end
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            s1_we    <= '0;
            fwd_we   <= '0;
            rd_re_q  <= '0;
            o_rvalid <= '0;
            o_rd     <= '0;
            for (int w = 0; w < N_WR; w++) begin
                s1_wa[w]   <= '0;
                s1_wd[w]   <= '0;
                fwd_wa[w]  <= '0;
                fwd_din[w] <= '0;
            end
            for (int r = 0; r < N_RD; r++) rd_ra_q[r] <= '0;
        end else begin
            s1_we    <= we_s0;
            fwd_we   <= s1_we;
            rd_re_q  <= i_re & {N_RD{o_ready}};
            o_rvalid <= rd_re_q;
            for (int w = 0; w < N_WR; w++) begin
                s1_wa[w]   <= i_wa[w*ADDR_WIDTH +: ADDR_WIDTH];
                s1_wd[w]   <= i_wd[w*DATA_WIDTH +: DATA_WIDTH];
                fwd_wa[w]  <= s1_wa[w];
                fwd_din[w] <= din[w];
            end
            for (int r = 0; r < N_RD; r++) begin
                rd_ra_q[r] <= i_ra[r*ADDR_WIDTH +: ADDR_WIDTH];
                if (rd_re_q[r]) o_rd[r*DATA_WIDTH +: DATA_WIDTH] <= rd_next[r];
            end
        end
    end

    // Banks 0..N_WR-2 of port w feed the other write ports; the rest feed the read ports.
    for (genvar w = 0; w < N_WR; w++) begin : g_wport
        for (genvar b = 0; b < N_BANK; b++) begin : g_bank
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [ADDR_WIDTH-1:0] rd_addr;
            logic [DATA_WIDTH-1:0] q;

            if (b < N_WR - 1) begin : g_fb
                localparam int V = (b < w) ? b : b + 1;
                assign rd_addr = i_wa[V*ADDR_WIDTH +: ADDR_WIDTH];
            end else begin : g_rp
                assign rd_addr = i_ra[(b - N_WR + 1)*ADDR_WIDTH +: ADDR_WIDTH];
            end

            // NOTE: the array has no reset; the clear sweep zeroes it so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (clearing)
                    mem[clr_cnt[ADDR_WIDTH-1:0]] <= '0;
                else if (s1_we[w])
                    mem[s1_wa[w]] <= din[w];
                q <= mem[rd_addr];
            end

            assign bank_q[w][b] = q;
        end
    end
endmodule

// File: tb/tb_xor_multiport_ram.sv
// Self-checking bench for xor_multiport_ram (ADDR_WIDTH=4): directed scenarios plus
// randomized traffic against an array model of the logical memory contents.
module tb_xor_multiport_ram;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NW    = 4;
    localparam int NR    = 4;
    localparam int DEPTH = 1 << AW;

    logic             clk = 1'b0;
    logic             i_rst;
    logic [NW-1:0]    i_we;
    logic [NW*AW-1:0] i_wa;
    logic [NW*DW-1:0] i_wd;
    logic [NR-1:0]    i_re;
    logic [NR*AW-1:0] i_ra;
    logic [NR*DW-1:0] o_rd;
    logic [NR-1:0]    o_rvalid;
    logic             o_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] model [DEPTH];

    xor_multiport_ram #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_WR(NW), .N_RD(NR)
    ) dut (
        .clk(clk), .i_rst(i_rst), .i_we(i_we), .i_wa(i_wa), .i_wd(i_wd),
        .i_re(i_re), .i_ra(i_ra), .o_rd(o_rd), .o_rvalid(o_rvalid), .o_ready(o_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rd_port(input int r);
        return o_rd[r*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_we = '0; i_wa = '0; i_wd = '0; i_re = '0; i_ra = '0;
    endtask

    task automatic wr(input int p, input int a, input logic [DW-1:0] d);
        i_we[p] = 1'b1;
        i_wa[p*AW +: AW] = AW'(a);
        i_wd[p*DW +: DW] = d;
    endtask

    task automatic rd(input int p, input int a);
        i_re[p] = 1'b1;
        i_ra[p*AW +: AW] = AW'(a);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!o_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        idle();
        i_rst = 1'b1;
        tick(); tick();
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
        vectors++; if (o_rvalid !== '0) begin miscompares++; $display("FAIL reset_rvalid: got %b expected 0", o_rvalid); end
        vectors++; if (o_rd !== '0) begin miscompares++; $display("FAIL reset_rd: got %h expected 0", o_rd); end
        i_rst = 1'b0;
        wait_ready(n);
        vectors++; if (n != DEPTH) begin miscompares++; $display("FAIL clear_cycles: got %0d expected %0d", n, DEPTH); end
        foreach (model[i]) model[i] = '0;
        // Pipelined read of every address, four per cycle.
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c < DEPTH / NR)
                for (int r = 0; r < NR; r++) rd(r, c*NR + r);
            tick();
            if (c == 0) begin
                vectors++; if (o_rvalid !== '0) begin miscompares++; $display("FAIL rvalid_latency: got %b expected 0", o_rvalid); end
            end else begin
                logic [NR-1:0] exp_v;
                exp_v = (c - 1 < DEPTH / NR) ? '1 : '0;
                vectors++; if (o_rvalid !== exp_v) begin miscompares++; $display("FAIL clear_rvalid c%0d: got %b expected %b", c, o_rvalid, exp_v); end
                if (exp_v != '0)
                    for (int r = 0; r < NR; r++) begin
                        vectors++; if (rd_port(r) !== '0) begin miscompares++; $display("FAIL clear_read a%0d: got %h expected 0", (c-1)*NR + r, rd_port(r)); end
                    end
            end
        end
        idle();
    endtask

    task automatic test_write_read();
        idle(); wr(0, 3, 32'hDEADBEEF); rd(1, 3); tick();
        idle(); rd(2, 3); tick();
        vectors++; if (o_rvalid !== 4'b0010) begin miscompares++; $display("FAIL wr_rd_rvalid1: got %b expected 0010", o_rvalid); end
        vectors++; if (rd_port(1) !== '0) begin miscompares++; $display("FAIL read_before_write: got %h expected 0", rd_port(1)); end
        idle(); tick();
        vectors++; if (o_rvalid !== 4'b0100) begin miscompares++; $display("FAIL wr_rd_rvalid2: got %b expected 0100", o_rvalid); end
        vectors++; if (rd_port(2) !== 32'hDEADBEEF) begin miscompares++; $display("FAIL write_then_read: got %h expected deadbeef", rd_port(2)); end
        model[3] = 32'hDEADBEEF;
    endtask

    task automatic test_back_to_back();
        idle(); wr(0, 5, 32'h11); tick();
        idle(); wr(1, 5, 32'h22); rd(0, 5); tick();
        idle(); wr(3, 5, 32'h33); rd(1, 5); tick();
        vectors++; if (rd_port(0) !== 32'h11) begin miscompares++; $display("FAIL b2b_first: got %h expected 11", rd_port(0)); end
        idle(); rd(2, 5); tick();
        vectors++; if (rd_port(1) !== 32'h22) begin miscompares++; $display("FAIL b2b_second: got %h expected 22", rd_port(1)); end
        idle(); tick();
        vectors++; if (rd_port(2) !== 32'h33) begin miscompares++; $display("FAIL b2b_third: got %h expected 33", rd_port(2)); end
        model[5] = 32'h33;
    endtask

    task automatic test_conflict();
        idle(); wr(1, 7, 32'hA); wr(2, 7, 32'hB); wr(3, 7, 32'hC); wr(0, 8, 32'h77); tick();
        idle(); for (int r = 0; r < NR; r++) rd(r, 7); tick();
        idle(); tick();
        for (int r = 0; r < NR; r++) begin
            vectors++; if (rd_port(r) !== 32'hA) begin miscompares++; $display("FAIL conflict_fwd p%0d: got %h expected a", r, rd_port(r)); end
        end
        idle(); rd(0, 8); for (int r = 1; r < NR; r++) rd(r, 7); tick();
        idle(); tick();
        vectors++; if (rd_port(0) !== 32'h77) begin miscompares++; $display("FAIL conflict_other: got %h expected 77", rd_port(0)); end
        for (int r = 1; r < NR; r++) begin
            vectors++; if (rd_port(r) !== 32'hA) begin miscompares++; $display("FAIL conflict_mem p%0d: got %h expected a", r, rd_port(r)); end
        end
        model[7] = 32'hA;
        model[8] = 32'h77;
    endtask

    task automatic shuffle(output int perm [DEPTH]);
        for (int i = 0; i < DEPTH; i++) perm[i] = i;
        for (int i = DEPTH - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
    endtask

    task automatic test_random();
        int            n;
        int            wperm [DEPTH];
        int            rperm [DEPTH];
        logic [DW-1:0] last   [NR];
        logic          prev_v [NR];
        logic [DW-1:0] prev_d [NR];
        logic          cur_v  [NR];
        logic [DW-1:0] cur_d  [NR];
        logic          w_en   [NW];
        int            w_a    [NW];
        logic [DW-1:0] w_d    [NW];

        idle();
        i_rst = 1'b1; tick(); i_rst = 1'b0;
        wait_ready(n);
        vectors++; if (n != DEPTH) begin miscompares++; $display("FAIL rand_clear_cycles: got %0d expected %0d", n, DEPTH); end
        foreach (model[i]) model[i] = '0;
        for (int r = 0; r < NR; r++) begin last[r] = '0; prev_v[r] = 1'b0; prev_d[r] = '0; end

        for (int c = 0; c < 1002; c++) begin
            idle();
            shuffle(wperm);
            shuffle(rperm);
            for (int w = 0; w < NW; w++) begin
                w_en[w] = (c < 1000) && ($urandom_range(9, 0) < 8);
                w_a[w]  = wperm[w];
                if (w > 0 && $urandom_range(9, 0) == 0) w_a[w] = wperm[$urandom_range(w - 1, 0)];
                w_d[w]  = $urandom();
                if (w_en[w]) wr(w, w_a[w], w_d[w]);
            end
            for (int r = 0; r < NR; r++) begin
                cur_v[r] = (c < 1000) && ($urandom_range(19, 0) < 17);
                cur_d[r] = model[rperm[r]];
                if (cur_v[r]) rd(r, rperm[r]);
            end
            // Highest index first so the lowest-index writer to an address ends up in the model.
            for (int w = NW - 1; w >= 0; w--)
                if (w_en[w]) model[w_a[w]] = w_d[w];
            tick();
            for (int r = 0; r < NR; r++) begin
                if (prev_v[r]) last[r] = prev_d[r];
                vectors++; if (o_rvalid[r] !== prev_v[r]) begin miscompares++; $display("FAIL rand_rvalid c%0d p%0d: got %b expected %b", c, r, o_rvalid[r], prev_v[r]); end
                vectors++; if (rd_port(r) !== last[r]) begin miscompares++; $display("FAIL rand_rd c%0d p%0d: got %h expected %h", c, r, rd_port(r), last[r]); end
                prev_v[r] = cur_v[r];
                prev_d[r] = cur_d[r];
            end
        end
        idle();
    endtask

    task automatic test_mid_reset();
        int n;
        idle(); wr(0, 9, 32'h5A5A0009); tick();
        idle(); rd(3, 9); wr(1, 9, 32'h12345678); wr(2, 4, 32'hCAFEF00D); tick();
        idle(); wr(3, 9, 32'h0BAD0BAD); tick();
        vectors++; if (rd_port(3) !== 32'h5A5A0009) begin miscompares++; $display("FAIL pre_reset_read: got %h expected 5a5a0009", rd_port(3)); end
        i_rst = 1'b1;
        #1;
        vectors++; if (o_rd !== '0) begin miscompares++; $display("FAIL midrst_rd: got %h expected 0", o_rd); end
        vectors++; if (o_rvalid !== '0) begin miscompares++; $display("FAIL midrst_rvalid: got %b expected 0", o_rvalid); end
        vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready: got %b expected 0", o_ready); end
        idle(); tick(); tick();
        i_rst = 1'b0;
        wait_ready(n);
        vectors++; if (n != DEPTH) begin miscompares++; $display("FAIL midrst_clear_cycles: got %0d expected %0d", n, DEPTH); end
        idle(); rd(0, 9); rd(1, 4); rd(2, 9); rd(3, 9); tick();
        idle(); tick();
        for (int r = 0; r < NR; r++) begin
            vectors++; if (rd_port(r) !== '0) begin miscompares++; $display("FAIL post_reset_read p%0d: got %h expected 0", r, rd_port(r)); end
        end
        vectors++; if (o_rvalid !== '1) begin miscompares++; $display("FAIL post_reset_rvalid: got %b expected 1111", o_rvalid); end
    endtask

    initial begin
        idle();
        i_rst = 1'b1;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_conflict();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
